// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiply-add unit among N requesters.
// Issues at most one operand triple per cycle and tags results with the requester index.
module mac_rr_arbiter #(
    parameter int unsigned S   = 8,
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 3,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    input  logic [N*S-1:0]   req_a_i,
    input  logic [N*S-1:0]   req_b_i,
    input  logic [N*S-1:0]   req_c_i,
    output logic [S-1:0]     mac_a_o,
    output logic [S-1:0]     mac_b_o,
    output logic [S-1:0]     mac_c_o,
    output logic             mac_issue_o,
    input  logic [2*S-1:0]   mac_result_i,
    output logic             rsp_valid_o,
    output logic [IW-1:0]    rsp_id_o,
    output logic [2*S-1:0]   rsp_data_o,
    output logic             busy_o
);

    logic [IW-1:0]         ptr_q, ptr_d;
    logic [S-1:0]          mac_a_q, mac_b_q, mac_c_q;
    logic                  mac_issue_q;
    logic [LAT:0]          tag_vld_q;
    logic [LAT:0][IW-1:0]  tag_id_q;

    logic                  gnt_found;
    logic [IW-1:0]         gnt_idx;
    logic [N-1:0]          gnt_oh;
    int unsigned           cand_w;
    logic [IW-1:0]         cand_idx;
    logic                  xfer;

    // Search from ptr upward, wrapping modulo N; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_w    = 0;
        cand_idx  = '0;
        if (!reset_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand_w   = (32'(ptr_q) + k) % N;
                cand_idx = cand_w[IW-1:0];
                if (!gnt_found && req_valid_i[cand_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand_idx;
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = gnt_oh;
    assign xfer        = gnt_found;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (32'(gnt_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            mac_issue_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            mac_issue_q <= xfer;
            if (xfer) begin
                mac_a_q <= req_a_i[32'(gnt_idx)*S +: S];
                mac_b_q <= req_b_i[32'(gnt_idx)*S +: S];
                mac_c_q <= req_c_i[32'(gnt_idx)*S +: S];
            end
        end
    end

    // Stage 0 is aligned with mac_issue; the last stage lines up with mac_result.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= xfer;
            tag_id_q[0]  <= gnt_idx;
            for (int unsigned k = 1; k <= LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    assign mac_a_o     = mac_a_q;
    assign mac_b_o     = mac_b_q;
    assign mac_c_o     = mac_c_q;
    assign mac_issue_o = mac_issue_q;

    assign rsp_valid_o = tag_vld_q[LAT];
    assign rsp_id_o    = tag_vld_q[LAT] ? tag_id_q[LAT] : '0;
    assign rsp_data_o  = tag_vld_q[LAT] ? mac_result_i : '0;
    assign busy_o      = |tag_vld_q;

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Scoreboard bench for mac_rr_arbiter: a reference arbiter and MAC model produce expected
// grants, registered operands and tagged responses; a separate monitor checks responses.
module tb_mac_rr_arbiter;
    localparam int S   = 8;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IW  = 2;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic [N-1:0]     req_valid_i = '0;
    logic [N-1:0]     req_ready_o;
    logic [N*S-1:0]   req_a_i = '0, req_b_i = '0, req_c_i = '0;
    logic [S-1:0]     mac_a_o, mac_b_o, mac_c_o;
    logic             mac_issue_o;
    logic [2*S-1:0]   mac_result_i;
    logic             rsp_valid_o;
    logic [IW-1:0]    rsp_id_o;
    logic [2*S-1:0]   rsp_data_o;
    logic             busy_o;

    mac_rr_arbiter #(.S(S), .N(N), .LAT(LAT)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_c_i      (req_c_i),
        .mac_a_o      (mac_a_o),
        .mac_b_o      (mac_b_o),
        .mac_c_o      (mac_c_o),
        .mac_issue_o  (mac_issue_o),
        .mac_result_i (mac_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural MAC: result in a cycle is a*b+c of the operands shown LAT cycles earlier.
    logic [2*S-1:0] hist [LAT];
    initial for (int k = 0; k < LAT; k++) hist[k] = '0;
    always @(posedge clk_i) begin
        hist[0] <= (2*S)'(mac_a_o) * (2*S)'(mac_b_o) + (2*S)'(mac_c_o);
        for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
    end
    assign mac_result_i = hist[LAT-1];

    typedef struct {
        int unsigned       id;
        longint unsigned   data;
        int unsigned       due;
    } exp_t;
    exp_t sb_q[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference model state
    logic        m_issue = 1'b0;
    logic [S-1:0] m_a = '0, m_b = '0, m_c = '0;
    int          m_ptr = 0;
    bit          prev_rst = 1'b0;

    task automatic step(input bit rst, input logic [N-1:0] v,
                        input logic [N*S-1:0] a, input logic [N*S-1:0] b,
                        input logic [N*S-1:0] c);
        int g;
        logic [N-1:0] exp_rdy;
        @(posedge clk_i);
        #1;
        reset_i = rst;
        req_valid_i = v;
        req_a_i = a;
        req_b_i = b;
        req_c_i = c;
        #2;
        chk("mac_issue", mac_issue_o, m_issue);
        chk("mac_a", mac_a_o, m_a);
        chk("mac_b", mac_b_o, m_b);
        chk("mac_c", mac_c_o, m_c);
        if (prev_rst) sb_q.delete();
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready_o, exp_rdy);
        if (rst) begin
            m_issue = 1'b0;
            m_a = '0; m_b = '0; m_c = '0;
            m_ptr = 0;
        end else if (g >= 0) begin
            m_issue = 1'b1;
            m_a = a[g*S +: S];
            m_b = b[g*S +: S];
            m_c = c[g*S +: S];
            m_ptr = (g + 1) % N;
            sb_q.push_back('{id: g,
                             data: longint'(m_a) * longint'(m_b) + longint'(m_c),
                             due: cyc + 1 + LAT});
        end else begin
            m_issue = 1'b0;
        end
        prev_rst = rst;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, '0);
    endtask

    // Monitor: busy, response presence, order, tag, data and timing.
    initial begin
        exp_t e;
        bit exp_busy;
        forever begin
            @(negedge clk_i);
            exp_busy = 1'b0;
            foreach (sb_q[i]) if (sb_q[i].due <= cyc + LAT) exp_busy = 1'b1;
            chk("busy", busy_o, exp_busy);
            if (rsp_valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected none at cycle %0d",
                             rsp_id_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", rsp_id_o, e.id);
                    chk("rsp_data", rsp_data_o, e.data);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else begin
                chk("rsp_data_idle", rsp_data_o, 0);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    n_chk++;
                    $display("FAIL rsp_missing: got rsp_valid=%b expected 1 (id %0d) at cycle %0d",
                             rsp_valid_o, sb_q[0].id, cyc);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*S-1:0] a, b, c;
        int guard;

        step(1'b1, '0, '0, '0, '0);
        step(1'b1, '0, '0, '0, '0);

        // Single op: 3*4+5 on requester 0
        step(1'b0, 4'b0001, 32'd3, 32'd4, 32'd5);
        idle(6);

        // Full contention, distinct operands
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                a[i*S +: S] = S'(k*4 + i + 1);
                b[i*S +: S] = S'(k*4 + i + 7);
                c[i*S +: S] = S'(k*16 + i);
            end
            step(1'b0, 4'b1111, a, b, c);
        end
        idle(5);

        // Rotation: 2 alone, then 1010 -> 3 then 1
        a = 32'h0a0b0c0d; b = 32'h11121314; c = 32'h21222324;
        step(1'b0, 4'b0100, a, b, c);
        step(1'b0, 4'b1010, a, b, c);
        step(1'b0, 4'b1010, a, b, c);
        idle(5);

        // Max operands: 255*255+255 = 65280
        step(1'b0, 4'b1000, '1, '1, '1);
        idle(6);

        // Reset mid-flight
        step(1'b0, 4'b0001, 32'h01020304, 32'h05060708, 32'h090a0b0c);
        step(1'b0, 4'b0010, 32'h01020304, 32'h05060708, 32'h090a0b0c);
        step(1'b1, 4'b1111, 32'h01020304, 32'h05060708, 32'h090a0b0c);
        idle(7);
        step(1'b0, 4'b1111, 32'h11223344, 32'h55667788, 32'h99aabbcc);
        idle(5);

        // Idle: outputs hold, nothing issued
        idle(10);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), N'($urandom), 32'($urandom),
                 32'($urandom), 32'($urandom));
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        idle(2);
        n_chk++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d outstanding expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_rr_arbiter.md
# mac_rr_arbiter

Round-robin arbiter that shares one pipelined unsigned multiply-add unit (result = a*b + c, fixed latency) among N requesters. It accepts operand triples over per-requester valid/ready handshakes and issues at most one triple per cycle to the MAC. It tags each issue with the requester index and returns the MAC result with that index when it emerges from the pipeline. It sits between the requesting blocks and the single multiply-add datapath.

## Interface
- S, default 8: operand width (bits); result width is 2*S.
- N, default 4: number of requesters, N >= 2; IW = $clog2(N).
- LAT, default 3: MAC latency, counted in cycles from the cycle operands are presented on mac_* to the cycle mac_result is valid.
- clk  in  1  the only clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N  bit i: requester i presents an operand triple.
- req_ready  out  N  one-hot or zero; bit i: triple i accepted this cycle.
- req_a  in  N*S  packed; requester i at [i*S +: S].
- req_b  in  N*S  packed, same layout.
- req_c  in  N*S  packed, same layout.
- mac_a  out  S  registered operand a to the MAC.
- mac_b  out  S  registered operand b to the MAC.
- mac_c  out  S  registered operand c to the MAC.
- mac_issue  out  1  registered; mac_a/b/c carry a newly accepted triple this cycle.
- mac_result  in  2*S  MAC output.
- rsp_valid  out  1  a tagged result is on rsp_data this cycle.
- rsp_id  out  IW  index of the requester owning rsp_data.
- rsp_data  out  2*S  mac_result when rsp_valid = 1, else 0.
- busy  out  1  at least one accepted triple has not yet been returned.

## Operation
- Priority pointer ptr (IW bits) is reset to 0.
- Each cycle, grant the first i with req_valid[i] = 1, searching ptr, ptr+1, … mod N.
  - req_ready[i] = 1 for that i only; combinational from req_valid and ptr.
  - A transfer occurs when req_valid[i] && req_ready[i].
- On a transfer from requester g:
  - mac_a/b/c load req_a/b/c slice g.
  - mac_issue <= 1.
  - ptr <= (g+1) mod N.
- With no transfer: mac_issue <= 0, mac_a/b/c hold their value, ptr holds.
- Requesters must hold req_valid and operands stable until accepted. The arbiter tolerates req_valid dropping before acceptance; the dropped request is simply not granted.
- Tag pipeline: LAT+1 stages of {valid, id}.
  - Stage 0 loads {transfer, g} at each edge.
  - Each stage shifts every cycle.
  - The last stage drives rsp_valid and rsp_id.
- The MAC cannot stall, so there is no back-pressure on rsp_*. Responses are returned in issue order.
- Arithmetic is unsigned. (2^S-1)^2 + (2^S-1) < 2^(2S), so no overflow is possible and no saturation logic is needed.
- busy = OR of all tag-pipeline valid bits.

## Timing
- Transfer in cycle T:
  - mac_a/b/c and mac_issue = 1 are visible in cycle T+1.
  - rsp_valid = 1 with the matching rsp_id/rsp_data in cycle T+1+LAT (T+4 at default).
- Throughput is one transfer per cycle. Back-to-back transfers give back-to-back responses.
- Reset values:
  - req_ready = 0 while reset is high.
  - mac_a/b/c = 0, mac_issue = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - ptr = 0; all tag valid bits are cleared.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is produced for them in any later cycle, regardless of what mac_result shows. The first transfer after reset deasserts can occur in the first cycle reset is low.
- Pointer wrap: after granting N-1, ptr = 0.
- All N requesting at once: grants rotate 0,1,…,N-1,0 (from reset), one per cycle, with no starvation. Worst-case wait for any requester is N-1 cycles.
- Single requester valid continuously: it is granted every cycle.

## Test plan
- Bench uses a behavioural MAC model: it returns a*b+c of the operands presented LAT cycles earlier.
- Single op: after reset, in cycle T set req_valid=0001, a0=3, b0=4, c0=5 -> req_ready=0001 in T; mac_a=3, mac_b=4, mac_c=5, mac_issue=1 in T+1; rsp_valid=1, rsp_id=0, rsp_data=17 in T+4; busy=0 from T+5.
- Full contention: req_valid=1111 held for 8 cycles with distinct operands -> grants 0,1,2,3,0,1,2,3 one per cycle; rsp_id sequence 0,1,2,3,0,1,2,3 back-to-back; every rsp_data equals the model value.
- Rotation: grant requester 2 alone, then next cycle set req_valid=1010 -> requester 3 granted first, requester 1 the following cycle.
- Max values: a=b=c=255 (S=8) -> rsp_data=65280.
- Reset mid-flight: two transfers in T and T+1, reset high in T+2 for one cycle -> rsp_valid stays 0 through T+8; busy=0 and mac_* = 0 after reset; next grant goes to requester 0 if valid.
- Idle: req_valid=0000 for 10 cycles -> req_ready=0, mac_issue=0, mac_a/b/c hold their last values, rsp_valid=0, busy=0 after drain.
